rdcost_search: RTL and testbench

- Parametrised successor to the single-candidate RD-cost accumulator in the affine ME path.
- Accumulates a stream of 4x4 SATD values per candidate, with a run-time sub-block count. Adds a lambda-weighted rate term with a fractional lambda shift, and saturates the result.
- Evaluates up to MAX_CAND candidates per search and tracks the minimum-cost candidate.
- Sits between the had4x4 array and the affine mode-decision controller.

---
 rtl/rdcost_search.sv | 217 +++++++++++++++++++++
 tb/tb_rdcost_search.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdcost_search.sv
// RD-cost search: accumulates 4x4 SATD beats per candidate, adds a lambda-weighted
// rate term, saturates, and tracks the minimum-cost candidate across a search.
module rdcost_search #(
    parameter int unsigned SATD_W      = 16,
    parameter int unsigned BITS_W      = 21,
    parameter int unsigned LAMBDA_W    = 9,
    parameter int unsigned LAMBDA_FRAC = 0,
    parameter int unsigned COST_W      = 24,
    parameter int unsigned NSUB_W      = 8,
    parameter int unsigned MAX_CAND    = 8,
    parameter int unsigned IDX_W       = $clog2(MAX_CAND)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_start,
    input  logic [LAMBDA_W-1:0] cfg_lambda,
    input  logic [NSUB_W-1:0]   cfg_num_sub,
    input  logic [IDX_W:0]      cfg_num_cand,
    input  logic                satd_valid,
    output logic                satd_ready,
    input  logic [SATD_W-1:0]   satd_4x4,
    input  logic                bits_valid,
    output logic                bits_ready,
    input  logic [BITS_W-1:0]   bits,
    output logic                busy,
    output logic                cand_done,
    output logic [COST_W-1:0]   cand_cost,
    output logic [IDX_W-1:0]    cand_idx,
    output logic                best_done,
    output logic [COST_W-1:0]   best_cost,
    output logic [IDX_W-1:0]    best_idx
);

    localparam int unsigned PROD_W = LAMBDA_W + BITS_W;
    localparam int unsigned SUM_W  = ((PROD_W > COST_W) ? PROD_W : COST_W) + 1;
    localparam logic [COST_W-1:0] COST_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_WAIT_BITS,
        S_COST
    } state_t;

    state_t              state_q, state_d;
    logic [LAMBDA_W-1:0] lambda_q, lambda_d;
    logic [NSUB_W-1:0]   num_sub_q, num_sub_d;
    logic [IDX_W:0]      num_cand_q, num_cand_d;
    logic [COST_W-1:0]   acc_q, acc_d;
    logic [NSUB_W-1:0]   sub_cnt_q, sub_cnt_d;
    logic [IDX_W-1:0]    cand_cnt_q, cand_cnt_d;
    logic [BITS_W-1:0]   bits_q, bits_d;
    logic                bits_got_q, bits_got_d;
    logic                cand_done_q, cand_done_d;
    logic [COST_W-1:0]   cand_cost_q, cand_cost_d;
    logic [IDX_W-1:0]    cand_idx_q, cand_idx_d;
    logic                best_done_q, best_done_d;
    logic [COST_W-1:0]   best_cost_q, best_cost_d;
    logic [IDX_W-1:0]    best_idx_q, best_idx_d;

    logic                satd_beat, bits_acc, sub_last, cand_last;
    logic [COST_W:0]     acc_sum;
    logic [COST_W-1:0]   acc_sat;
    logic [PROD_W-1:0]   prod, rate;
    logic [SUM_W-1:0]    cost_sum;
    logic [COST_W-1:0]   cost;
    logic [NSUB_W-1:0]   num_sub_n;
    logic [IDX_W:0]      num_cand_n;

    assign satd_ready = (state_q == S_ACCUM);
    assign bits_ready = ((state_q == S_ACCUM) || (state_q == S_WAIT_BITS)) && !bits_got_q;
    assign busy       = (state_q != S_IDLE);

    assign cand_done = cand_done_q;
    assign cand_cost = cand_cost_q;
    assign cand_idx  = cand_idx_q;
    assign best_done = best_done_q;
    assign best_cost = best_cost_q;
    assign best_idx  = best_idx_q;

    // Datapath: sticky-saturating accumulate and the final cost add.
    always_comb begin
        satd_beat = satd_valid && satd_ready;
        bits_acc  = bits_valid && bits_ready;
        acc_sum   = {1'b0, acc_q} + (COST_W+1)'(satd_4x4);
        acc_sat   = acc_sum[COST_W] ? COST_MAX : acc_sum[COST_W-1:0];
        prod      = PROD_W'(lambda_q) * PROD_W'(bits_q);
        rate      = prod >> LAMBDA_FRAC;
        cost_sum  = SUM_W'(acc_q) + SUM_W'(rate);
        cost      = (cost_sum > SUM_W'(COST_MAX)) ? COST_MAX : cost_sum[COST_W-1:0];
        sub_last  = ((NSUB_W+1)'(sub_cnt_q) + (NSUB_W+1)'(1)) == {1'b0, num_sub_q};
        cand_last = {1'b0, cand_cnt_q} == (num_cand_q - (IDX_W+1)'(1));
        num_sub_n = (cfg_num_sub == '0) ? NSUB_W'(1) : cfg_num_sub;
        if (cfg_num_cand == '0) begin
            num_cand_n = (IDX_W+1)'(1);
        end else if (cfg_num_cand > (IDX_W+1)'(MAX_CAND)) begin
            num_cand_n = (IDX_W+1)'(MAX_CAND);
        end else begin
            num_cand_n = cfg_num_cand;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        lambda_d    = lambda_q;
        num_sub_d   = num_sub_q;
        num_cand_d  = num_cand_q;
        acc_d       = acc_q;
        sub_cnt_d   = sub_cnt_q;
        cand_cnt_d  = cand_cnt_q;
        bits_d      = bits_q;
        bits_got_d  = bits_got_q;
        cand_done_d = 1'b0;
        cand_cost_d = cand_cost_q;
        cand_idx_d  = cand_idx_q;
        best_done_d = 1'b0;
        best_cost_d = best_cost_q;
        best_idx_d  = best_idx_q;

        if (cfg_start) begin
            // A start in any state re-initialises; an in-flight search is dropped silently.
            lambda_d    = cfg_lambda;
            num_sub_d   = num_sub_n;
            num_cand_d  = num_cand_n;
            acc_d       = '0;
            sub_cnt_d   = '0;
            cand_cnt_d  = '0;
            bits_got_d  = 1'b0;
            best_cost_d = COST_MAX;
            best_idx_d  = '0;
            state_d     = S_ACCUM;
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (bits_acc) begin
                        bits_d     = bits;
                        bits_got_d = 1'b1;
                    end
                    if (satd_beat) begin
                        acc_d     = acc_sat;
                        sub_cnt_d = sub_cnt_q + NSUB_W'(1);
                        if (sub_last) begin
                            state_d = (bits_got_q || bits_acc) ? S_COST : S_WAIT_BITS;
                        end
                    end
                end
                S_WAIT_BITS: begin
                    if (bits_acc) begin
                        bits_d     = bits;
                        bits_got_d = 1'b1;
                        state_d    = S_COST;
                    end
                end
                S_COST: begin
                    cand_cost_d = cost;
                    cand_idx_d  = cand_cnt_q;
                    cand_done_d = 1'b1;
                    if (cost < best_cost_q) begin
                        best_cost_d = cost;
                        best_idx_d  = cand_cnt_q;
                    end
                    if (cand_last) begin
                        best_done_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        cand_cnt_d = cand_cnt_q + IDX_W'(1);
                        acc_d      = '0;
                        sub_cnt_d  = '0;
                        bits_got_d = 1'b0;
                        state_d    = S_ACCUM;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            lambda_q    <= '0;
            num_sub_q   <= '0;
            num_cand_q  <= '0;
            acc_q       <= '0;
            sub_cnt_q   <= '0;
            cand_cnt_q  <= '0;
            bits_q      <= '0;
            bits_got_q  <= 1'b0;
            cand_done_q <= 1'b0;
            cand_cost_q <= '0;
            cand_idx_q  <= '0;
            best_done_q <= 1'b0;
            best_cost_q <= COST_MAX;
            best_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            lambda_q    <= lambda_d;
            num_sub_q   <= num_sub_d;
            num_cand_q  <= num_cand_d;
            acc_q       <= acc_d;
            sub_cnt_q   <= sub_cnt_d;
            cand_cnt_q  <= cand_cnt_d;
            bits_q      <= bits_d;
            bits_got_q  <= bits_got_d;
            cand_done_q <= cand_done_d;
            cand_cost_q <= cand_cost_d;
            cand_idx_q  <= cand_idx_d;
            best_done_q <= best_done_d;
            best_cost_q <= best_cost_d;
            best_idx_q  <= best_idx_d;
        end
    end

endmodule

// File: tb/tb_rdcost_search.sv
// Bench for rdcost_search: directed and randomized searches against an arithmetic cost
// model, on a LAMBDA_FRAC=0 instance and a LAMBDA_FRAC=2 instance sharing the stimulus.
module tb_rdcost_search;

    localparam longint MAXC = 64'hFFFFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic [8:0]  cfg_lambda = '0;
    logic [7:0]  cfg_num_sub = '0;
    logic [3:0]  cfg_num_cand = '0;
    logic        satd_valid = 1'b0;
    logic [15:0] satd_4x4 = '0;
    logic        bits_valid = 1'b0;
    logic [20:0] bits = '0;

    logic        satd_ready, bits_ready, busy, cand_done, best_done;
    logic [23:0] cand_cost, best_cost;
    logic [2:0]  cand_idx, best_idx;
    logic        f_satd_ready, f_bits_ready, f_busy, f_cand_done, f_best_done;
    logic [23:0] f_cand_cost, f_best_cost;
    logic [2:0]  f_cand_idx, f_best_idx;

    int n_pass = 0;
    int n_total = 0;
    int cyc_cnt = 0;
    int last_evt_cyc = 0;

    logic [15:0] sat_vals [256];
    logic [23:0] q_cost[$];
    logic [2:0]  q_idx[$];
    int          q_cyc[$];
    logic [23:0] qf_cost[$];
    logic [23:0] bq_cost[$];
    logic [2:0]  bq_idx[$];
    int          bq_cyc[$];
    logic [23:0] bqf_cost[$];
    logic [2:0]  bqf_idx[$];

    rdcost_search u_dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_lambda(cfg_lambda),
        .cfg_num_sub(cfg_num_sub), .cfg_num_cand(cfg_num_cand),
        .satd_valid(satd_valid), .satd_ready(satd_ready), .satd_4x4(satd_4x4),
        .bits_valid(bits_valid), .bits_ready(bits_ready), .bits(bits), .busy(busy),
        .cand_done(cand_done), .cand_cost(cand_cost), .cand_idx(cand_idx),
        .best_done(best_done), .best_cost(best_cost), .best_idx(best_idx)
    );

    rdcost_search #(.LAMBDA_FRAC(2)) u_frac (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_lambda(cfg_lambda),
        .cfg_num_sub(cfg_num_sub), .cfg_num_cand(cfg_num_cand),
        .satd_valid(satd_valid), .satd_ready(f_satd_ready), .satd_4x4(satd_4x4),
        .bits_valid(bits_valid), .bits_ready(f_bits_ready), .bits(bits), .busy(f_busy),
        .cand_done(f_cand_done), .cand_cost(f_cand_cost), .cand_idx(f_cand_idx),
        .best_done(f_best_done), .best_cost(f_best_cost), .best_idx(f_best_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Result monitor: captures every done pulse with the cycle it was seen.
    always @(negedge clk) begin
        if (cand_done) begin
            q_cost.push_back(cand_cost); q_idx.push_back(cand_idx); q_cyc.push_back(cyc_cnt);
        end
        if (f_cand_done) qf_cost.push_back(f_cand_cost);
        if (best_done) begin
            bq_cost.push_back(best_cost); bq_idx.push_back(best_idx); bq_cyc.push_back(cyc_cnt);
        end
        if (f_best_done) begin
            bqf_cost.push_back(f_best_cost); bqf_idx.push_back(f_best_idx);
        end
    end

    function automatic longint model_cost(longint acc, longint lam, longint b, int frac);
        longint c;
        c = ((acc > MAXC) ? MAXC : acc) + ((lam * b) >> frac);
        return (c > MAXC) ? MAXC : c;
    endfunction

    task automatic clear_q();
        q_cost.delete(); q_idx.delete(); q_cyc.delete(); qf_cost.delete();
        bq_cost.delete(); bq_idx.delete(); bq_cyc.delete(); bqf_cost.delete(); bqf_idx.delete();
    endtask

    task automatic start_search(input int lam, input int nsub, input int ncand);
        @(negedge clk);
        cfg_lambda = 9'(lam); cfg_num_sub = 8'(nsub); cfg_num_cand = 4'(ncand);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Drives one candidate; bits are offered from loop cycle bits_at, dup keeps re-offering other bits.
    task automatic drive_cand(input int nsub, input int bits_at, input logic [20:0] b, input bit dup);
        int sent = 0;
        int cyc = 0;
        bit bdone = 1'b0;
        while ((sent < nsub || !bdone) && cyc < 1000) begin
            @(negedge clk);
            satd_valid = (sent < nsub);
            satd_4x4   = sat_vals[(sent < nsub) ? sent : 0];
            bits_valid = !bdone && (cyc >= bits_at);
            bits       = b;
            if (bdone && dup) begin
                bits_valid = 1'b1;
                bits = b ^ 21'h15555;
            end
            if (satd_valid && satd_ready) begin sent++; last_evt_cyc = cyc_cnt; end
            if (bits_valid && bits_ready && !bdone) begin bdone = 1'b1; last_evt_cyc = cyc_cnt; end
            cyc++;
        end
        if (cyc >= 1000) begin
            $display("FAIL drive_timeout: sent %0d of %0d beats, bits accepted %0d", sent, nsub, bdone);
            $fatal(1);
        end
        @(negedge clk);
        satd_valid = 1'b0; bits_valid = 1'b0;
    endtask

    task automatic wait_best();
        int t = 0;
        while (bq_cost.size() == 0 && t < 600) begin
            @(posedge clk); #1; t++;
        end
        if (bq_cost.size() == 0) begin
            $display("FAIL best_done_timeout: no best_done within %0d cycles", t);
            $fatal(1);
        end
    endtask

    task automatic test_reset();
        n_total++;
        if ({busy, satd_ready, bits_ready, cand_done, best_done} !== 5'b0)
            $display("FAIL reset_ctrl: got %b required 00000", {busy, satd_ready, bits_ready, cand_done, best_done});
        else n_pass++;
        n_total++;
        if (best_cost !== 24'hFFFFFF || best_idx !== 3'd0 || cand_cost !== 24'd0 || cand_idx !== 3'd0)
            $display("FAIL reset_vals: best_cost %h best_idx %0d cand_cost %h cand_idx %0d required ffffff 0 0 0",
                     best_cost, best_idx, cand_cost, cand_idx);
        else n_pass++;
    endtask

    task automatic test_single();
        clear_q();
        start_search(10, 4, 1);
        sat_vals[0] = 16'd10; sat_vals[1] = 16'd20; sat_vals[2] = 16'd30; sat_vals[3] = 16'd40;
        drive_cand(4, 1, 21'd5, 1'b0);
        wait_best();
        n_total++;
        if (q_cost.size() !== 1 || q_cost[0] !== 24'd150 || q_idx[0] !== 3'd0)
            $display("FAIL single_cand: n %0d cost %0d idx %0d required 1 150 0", q_cost.size(), q_cost[0], q_idx[0]);
        else n_pass++;
        n_total++;
        if (bq_cost[0] !== 24'd150 || bq_idx[0] !== 3'd0 || bq_cyc[0] !== q_cyc[0])
            $display("FAIL single_best: cost %0d idx %0d cyc %0d required 150 0 cyc %0d", bq_cost[0], bq_idx[0], bq_cyc[0], q_cyc[0]);
        else n_pass++;
        n_total++;
        if (q_cyc[0] - last_evt_cyc !== 2)
            $display("FAIL single_latency: got %0d cycles required 2", q_cyc[0] - last_evt_cyc);
        else n_pass++;
        n_total++;
        if (qf_cost.size() !== 1 || qf_cost[0] !== 24'd112)
            $display("FAIL single_frac: got %0d required 112", qf_cost[0]);
        else n_pass++;
    endtask

    task automatic test_three_cand();
        int pairs [6] = '{100, 200, 50, 150, 120, 80};
        logic [23:0] exp_c [3] = '{24'd300, 24'd200, 24'd200};
        clear_q();
        start_search(4, 2, 3);
        for (int c = 0; c < 3; c++) begin
            sat_vals[0] = 16'(pairs[2*c]); sat_vals[1] = 16'(pairs[2*c+1]);
            drive_cand(2, 0, 21'd0, 1'b0);
        end
        wait_best();
        n_total++;
        if (q_cost.size() !== 3) $display("FAIL three_count: got %0d required 3", q_cost.size());
        else n_pass++;
        for (int c = 0; c < 3 && c < q_cost.size(); c++) begin
            n_total++;
            if (q_cost[c] !== exp_c[c] || q_idx[c] !== 3'(c))
                $display("FAIL three_cand%0d: cost %0d idx %0d required %0d %0d", c, q_cost[c], q_idx[c], exp_c[c], c);
            else n_pass++;
        end
        n_total++;
        if (bq_cost[0] !== 24'd200 || bq_idx[0] !== 3'd1)
            $display("FAIL three_best_tie: cost %0d idx %0d required 200 1", bq_cost[0], bq_idx[0]);
        else n_pass++;
    endtask

    task automatic test_late_bits();
        int acc_cyc;
        clear_q();
        start_search(2, 1, 1);
        @(negedge clk); satd_valid = 1'b1; satd_4x4 = 16'd7;
        @(negedge clk); satd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({satd_ready, bits_ready, busy} !== 3'b011)
            $display("FAIL late_wait_state: satd_ready,bits_ready,busy %b required 011", {satd_ready, bits_ready, busy});
        else n_pass++;
        @(negedge clk); bits_valid = 1'b1; bits = 21'd3; acc_cyc = cyc_cnt;
        @(negedge clk); bits = 21'd50;
        @(negedge clk); bits_valid = 1'b0;
        wait_best();
        n_total++;
        if (q_cost.size() !== 1 || q_cost[0] !== 24'd13 || q_cyc[0] - acc_cyc !== 2)
            $display("FAIL late_bits: n %0d cost %0d lat %0d required 1 13 2", q_cost.size(), q_cost[0], q_cyc[0] - acc_cyc);
        else n_pass++;
    endtask

    task automatic test_saturation();
        clear_q();
        start_search(511, 255, 1);
        for (int k = 0; k < 255; k++) sat_vals[k] = 16'hFFFF;
        drive_cand(255, 0, 21'h1FFFFF, 1'b0);
        wait_best();
        n_total++;
        if (q_cost[0] !== 24'hFFFFFF || qf_cost[0] !== 24'hFFFFFF)
            $display("FAIL sat_max: got %h / %h required ffffff", q_cost[0], qf_cost[0]);
        else n_pass++;
        // acc = 16711425; bits 65790 lands exactly on the max, 65791 would exceed it by one.
        clear_q();
        start_search(1, 255, 2);
        drive_cand(255, 3, 21'd65790, 1'b0);
        drive_cand(255, 3, 21'd65791, 1'b0);
        wait_best();
        n_total++;
        if (q_cost.size() !== 2 || q_cost[0] !== 24'hFFFFFF || q_cost[1] !== 24'hFFFFFF || bq_idx[0] !== 3'd0)
            $display("FAIL sat_edge: c0 %h c1 %h best_idx %0d required ffffff ffffff 0", q_cost[0], q_cost[1], bq_idx[0]);
        else n_pass++;
        n_total++;
        if (qf_cost[0] !== 24'(model_cost(16711425, 1, 65790, 2)) || bqf_idx[0] !== 3'd0)
            $display("FAIL sat_edge_frac: got %0d idx %0d required %0d 0", qf_cost[0], bqf_idx[0], model_cost(16711425, 1, 65790, 2));
        else n_pass++;
    endtask

    task automatic test_frac();
        clear_q();
        start_search(6, 1, 1);
        sat_vals[0] = 16'd10;
        drive_cand(1, 0, 21'd3, 1'b0);
        wait_best();
        n_total++;
        if (qf_cost[0] !== 24'd14 || bqf_cost[0] !== 24'd14 || q_cost[0] !== 24'd28)
            $display("FAIL frac_lambda: frac %0d best %0d int %0d required 14 14 28", qf_cost[0], bqf_cost[0], q_cost[0]);
        else n_pass++;
    endtask

    task automatic test_random();
        longint exp_c[$];
        longint exp_f[$];
        longint acc, b;
        int lam, nsub_cfg, ncand_cfg, nsub, ncand, bi, bfi;
        for (int s = 0; s < 6; s++) begin
            lam = $urandom_range(0, 511);
            nsub_cfg = $urandom_range(0, 5);
            ncand_cfg = (s == 0) ? 0 : (s == 1) ? 12 : $urandom_range(0, 11);
            nsub = (nsub_cfg == 0) ? 1 : nsub_cfg;
            ncand = (ncand_cfg == 0) ? 1 : (ncand_cfg > 8) ? 8 : ncand_cfg;
            exp_c.delete(); exp_f.delete();
            clear_q();
            start_search(lam, nsub_cfg, ncand_cfg);
            for (int c = 0; c < ncand; c++) begin
                acc = 0;
                for (int k = 0; k < nsub; k++) begin
                    sat_vals[k] = 16'($urandom_range(0, 65535));
                    acc += longint'(sat_vals[k]);
                end
                b = $urandom_range(0, 1) ? longint'($urandom_range(0, 300)) : longint'($urandom & 32'h1FFFFF);
                exp_c.push_back(model_cost(acc, lam, b, 0));
                exp_f.push_back(model_cost(acc, lam, b, 2));
                drive_cand(nsub, $urandom_range(0, nsub + 3), 21'(b), 1'($urandom_range(0, 1)));
            end
            wait_best();
            bi = 0; bfi = 0;
            for (int c = 1; c < ncand; c++) begin
                if (exp_c[c] < exp_c[bi]) bi = c;
                if (exp_f[c] < exp_f[bfi]) bfi = c;
            end
            n_total++;
            if (q_cost.size() !== ncand || qf_cost.size() !== ncand)
                $display("FAIL rand%0d_count: got %0d/%0d required %0d", s, q_cost.size(), qf_cost.size(), ncand);
            else n_pass++;
            for (int c = 0; c < ncand && c < q_cost.size() && c < qf_cost.size(); c++) begin
                n_total++;
                if (q_cost[c] !== 24'(exp_c[c]) || qf_cost[c] !== 24'(exp_f[c]) || q_idx[c] !== 3'(c))
                    $display("FAIL rand%0d_cand%0d: cost %0d frac %0d idx %0d required %0d %0d %0d",
                             s, c, q_cost[c], qf_cost[c], q_idx[c], exp_c[c], exp_f[c], c);
                else n_pass++;
            end
            n_total++;
            if (bq_cost[0] !== 24'(exp_c[bi]) || bq_idx[0] !== 3'(bi) || bqf_cost[0] !== 24'(exp_f[bfi]) || bqf_idx[0] !== 3'(bfi))
                $display("FAIL rand%0d_best: %0d@%0d frac %0d@%0d required %0d@%0d %0d@%0d",
                         s, bq_cost[0], bq_idx[0], bqf_cost[0], bqf_idx[0], exp_c[bi], bi, exp_f[bfi], bfi);
            else n_pass++;
        end
    endtask

    task automatic test_abort();
        clear_q();
        start_search(3, 2, 3);
        sat_vals[0] = 16'd5; sat_vals[1] = 16'd5;
        drive_cand(2, 0, 21'd1, 1'b0);
        @(negedge clk); satd_valid = 1'b1; satd_4x4 = 16'd9;
        @(negedge clk); satd_valid = 1'b0;
        start_search(0, 1, 1);
        n_total++;
        if (best_cost !== 24'hFFFFFF || best_idx !== 3'd0 || busy !== 1'b1)
            $display("FAIL abort_reinit: best_cost %h best_idx %0d busy %b required ffffff 0 1", best_cost, best_idx, busy);
        else n_pass++;
        sat_vals[0] = 16'd21;
        drive_cand(1, 0, 21'd0, 1'b0);
        wait_best();
        n_total++;
        if (q_cost.size() !== 2 || q_cost[0] !== 24'd13 || q_cost[1] !== 24'd21 || q_idx[1] !== 3'd0)
            $display("FAIL abort_cands: n %0d c0 %0d c1 %0d idx1 %0d required 2 13 21 0", q_cost.size(), q_cost[0], q_cost[1], q_idx[1]);
        else n_pass++;
        n_total++;
        if (bq_cost.size() !== 1 || bq_cost[0] !== 24'd21 || bq_idx[0] !== 3'd0)
            $display("FAIL abort_best: n %0d cost %0d idx %0d required 1 21 0", bq_cost.size(), bq_cost[0], bq_idx[0]);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        start_search(1, 3, 2);
        @(negedge clk); satd_valid = 1'b1; satd_4x4 = 16'd50;
        @(negedge clk); satd_valid = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        n_total++;
        if ({busy, satd_ready, bits_ready, cand_done, best_done, f_busy} !== 6'b0)
            $display("FAIL async_rst_ctrl: got %b required 000000", {busy, satd_ready, bits_ready, cand_done, best_done, f_busy});
        else n_pass++;
        n_total++;
        if (best_cost !== 24'hFFFFFF || cand_cost !== 24'd0 || best_idx !== 3'd0 || f_best_cost !== 24'hFFFFFF)
            $display("FAIL async_rst_vals: best_cost %h cand_cost %h best_idx %0d frac best %h required ffffff 0 0 ffffff",
                     best_cost, cand_cost, best_idx, f_best_cost);
        else n_pass++;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_three_cand();
        test_late_bits();
        test_saturation();
        test_frac();
        test_random();
        test_abort();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
